// File: rtl/fp_mult_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_op_sequencer
// Summary  : Issue stage for fp_multiplier. Buffers operand pairs, drives the
//            multiplier operands and its active-high reset, times the setup
//            and run windows, and registers result/of/uf behind valid/ready.
//            Pairs with a zero operand bypass the multiplier (+0 result).
// Options  : FP_MULT_SEQ_PERF_EN - adds perf_ops / perf_bypass counters
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_op_sequencer #(
    parameter int WIDTH        = 32,
    parameter int SETUP_CYCLES = 3,
    parameter int RUN_CYCLES   = 50,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_rst,
    input  logic [WIDTH-1:0] mul_out,
    input  logic             mul_of,
    input  logic             mul_uf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_of,
    output logic             out_uf,
`ifdef FP_MULT_SEQ_PERF_EN
    output logic [15:0]      perf_ops,
    output logic [15:0]      perf_bypass,
`endif
    output logic             busy
);

    localparam int c_AW      = $clog2(FIFO_DEPTH);
    localparam int c_CW      = c_AW + 1;
    localparam int c_CNT_MAX = (SETUP_CYCLES > RUN_CYCLES) ? SETUP_CYCLES : RUN_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RUN_LAST   = c_CNT_W'(RUN_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_ZERO  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_mem_a [FIFO_DEPTH];
    logic [WIDTH-1:0]   r_mem_b [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_fifo_nonempty;
    logic               w_head_zero;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;

    // in_ready comes straight from the registered count: no pop-through when full
    assign in_ready        = (r_count != c_CW'(FIFO_DEPTH));
    assign w_push          = in_valid && in_ready;
    assign w_fifo_nonempty = (r_count != '0);
    assign w_head_a        = r_mem_a[r_rd_ptr];
    assign w_head_b        = r_mem_b[r_rd_ptr];
    // The sign bit is ignored: -0 is a zero operand too
    assign w_head_zero     = (w_head_a[WIDTH-2:0] == '0) || (w_head_b[WIDTH-2:0] == '0);

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next-state: a pop from IDLE or from a completed DONE branches the same way
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fifo_nonempty) w_next_state = w_head_zero ? c_ST_ZERO : c_ST_SETUP;
            end
            c_ST_SETUP: begin
                if (r_cnt == c_SETUP_LAST) w_next_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (r_cnt == c_RUN_LAST) w_next_state = c_ST_DONE;
            end
            c_ST_ZERO: begin
                w_next_state = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    if (w_fifo_nonempty) w_next_state = w_head_zero ? c_ST_ZERO : c_ST_SETUP;
                    else                 w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM outputs: multiplier is released only while RUN, results valid only in DONE
    always_comb begin
        mul_rst   = (r_state != c_ST_RUN);
        out_valid = (r_state == c_ST_DONE);
        w_capture = (r_state == c_ST_RUN) && (r_cnt == c_RUN_LAST);
        w_pop     = w_fifo_nonempty &&
                    ((r_state == c_ST_IDLE) || ((r_state == c_ST_DONE) && out_ready));
        busy      = (r_state != c_ST_IDLE) || w_fifo_nonempty;
    end

    // Phase counter restarts on every pop and on the SETUP->RUN hand-over
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_pop || ((r_state == c_ST_SETUP) && (r_cnt == c_SETUP_LAST))) begin
            r_cnt <= '0;
        end else if ((r_state == c_ST_SETUP) || (r_state == c_ST_RUN)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // FIFO storage needs no reset: the count alone decides what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand and result registers: operands move only on pop, results only at run end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a      <= '0;
            mul_b      <= '0;
            out_result <= '0;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
        end else begin
            if (w_pop) begin
                mul_a <= w_head_a;
                mul_b <= w_head_b;
            end
            if (w_capture) begin
                out_result <= mul_out;
                out_of     <= mul_of;
                out_uf     <= mul_uf;
            end else if (r_state == c_ST_ZERO) begin
                out_result <= '0;
                out_of     <= 1'b0;
                out_uf     <= 1'b0;
            end
        end
    end

`ifdef FP_MULT_SEQ_PERF_EN
    // Free-running wrap-around counters of handed-off results and zero bypasses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ops    <= '0;
            perf_bypass <= '0;
        end else begin
            if (out_valid && out_ready)  perf_ops    <= perf_ops + 16'(1);
            if (r_state == c_ST_ZERO)    perf_bypass <= perf_bypass + 16'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mult_op_sequencer
// Summary  : Bench for fp_mult_op_sequencer with a timing-aware multiplier
//            stand-in, a queue scoreboard, a vector table and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mult_op_sequencer;

    localparam int WIDTH        = 32;
    localparam int SETUP_CYCLES = 3;
    localparam int RUN_CYCLES   = 50;
    localparam int FIFO_DEPTH   = 2;
    localparam int c_LAT_RUN    = SETUP_CYCLES + RUN_CYCLES + 1;
    localparam int c_LAT_ZERO   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_rst;
    logic [WIDTH-1:0] mul_out;
    logic             mul_of;
    logic             mul_uf;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic             out_of;
    logic             out_uf;
    logic             busy;
`ifdef FP_MULT_SEQ_PERF_EN
    logic [15:0]      perf_ops;
    logic [15:0]      perf_bypass;
`endif

    int checks = 0;
    int errors = 0;

    fp_mult_op_sequencer #(
        .WIDTH(WIDTH), .SETUP_CYCLES(SETUP_CYCLES),
        .RUN_CYCLES(RUN_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst),
        .mul_out(mul_out), .mul_of(mul_of), .mul_uf(mul_uf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_of(out_of), .out_uf(out_uf),
`ifdef FP_MULT_SEQ_PERF_EN
        .perf_ops(perf_ops), .perf_bypass(perf_bypass),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: known IEEE products for the reference pairs, a fixed
    // scramble for anything else. Returns {of, uf, product}.
    function automatic logic [33:0] standin(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h49072340, 32'h44520000}: return {2'b00, 32'h4DDDB5D5};
            {32'h7F7FFFF0, 32'h41A00000}: return {2'b10, 32'h7F800000};
            {32'hFF7FFFF0, 32'h41A00000}: return {2'b10, 32'hFF800000};
            {32'h4EA0C8E4, 32'h4EA0C246}: return {2'b00, 32'h5DC9EF25};
            {32'h3F800000, 32'h4EA0C8E4}: return {2'b00, 32'h4EA0C8E4};
            {32'h00800000, 32'h00800000}: return {2'b01, 32'h00000000};
            default: return {a[1] & b[1], a[2] & b[2], a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0F0F};
        endcase
    endfunction

    // What the sequencer must hand off for one accepted pair
    function automatic logic [33:0] expect_of(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 34'd0;
        return standin(a, b);
    endfunction

    // Stand-in timing: product is only valid once operands were stable with the
    // reset high for SETUP_CYCLES cycles and the reset has been low RUN_CYCLES cycles.
    int          m_low = 0;
    int          m_hi = 0;
    bit          m_setup_ok = 1'b0;
    logic [31:0] m_pa = '0;
    logic [31:0] m_pb = '0;
    always @(posedge clk) begin
        if (mul_rst) begin
            m_low <= 0;
            m_hi  <= (mul_a == m_pa && mul_b == m_pb) ? m_hi + 1 : 1;
        end else begin
            if (m_low == 0) m_setup_ok <= (m_hi >= SETUP_CYCLES);
            m_low <= m_low + 1;
        end
        m_pa <= mul_a;
        m_pb <= mul_b;
    end
    assign {mul_of, mul_uf, mul_out} =
        (!mul_rst && m_setup_ok && m_low >= RUN_CYCLES - 1) ? standin(mul_a, mul_b)
                                                             : {2'b11, 32'hDEADBEEF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard and protocol monitor, sampling on the falling edge
    logic [33:0] exp_q[$];
    int          n_ops = 0;
    int          n_byp = 0;
    bit          saw_low = 1'b0;
    bit          stall = 1'b0;
    logic [33:0] stall_val = '0;
    always @(negedge clk) begin
        if (!reset) begin
            stall = 1'b0;
        end else begin
            if (!mul_rst) saw_low = 1'b1;
            if (stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_result", out_result, stall_val[31:0]);
                chk("hold_flags", {30'd0, out_of, out_uf}, {30'd0, stall_val[33:32]});
            end
            if (in_valid && in_ready) exp_q.push_back(expect_of(in_a, in_b));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    chk("sb_result", out_result, e[31:0]);
                    chk("sb_flags", {30'd0, out_of, out_uf}, {30'd0, e[33:32]});
                    n_ops++;
                    if (e == 34'd0) n_byp++;
                end
            end
            stall     = out_valid && !out_ready;
            stall_val = {out_of, out_uf, out_result};
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        of;
        logic        uf;
        int          lat;
    } vec_t;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            cycle();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // One pair into an empty pipe with out_ready=1; checks latency and outputs
    task automatic run_single(input vec_t v, input string tag);
        int n = 0;
        bit got = 1'b0;
        bit is_zero;
        is_zero   = (v.a[30:0] == 31'd0) || (v.b[30:0] == 31'd0);
        saw_low   = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        cycle();
        in_valid = 1'b0;
        while (!got && n < 200) begin
            cycle();
            n++;
            if (out_valid) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(v.lat));
        chk({tag, "_result"}, out_result, v.res);
        chk({tag, "_flags"}, {30'd0, out_of, out_uf}, {30'd0, v.of, v.uf});
        if (is_zero) chk({tag, "_mul_rst_low"}, {31'd0, saw_low}, 32'd0);
        wait_idle({tag, "_idle"});
    endtask

    vec_t vecs[9];
    vec_t v;
    logic [33:0] e;
    logic [31:0] ra;
    logic [31:0] rb;
    int left;
    int n;

    initial begin
        vecs[0] = '{32'h49072340, 32'h44520000, 32'h4DDDB5D5, 1'b0, 1'b0, c_LAT_RUN};
        vecs[1] = '{32'hCE8EF06B, 32'h00000000, 32'h00000000, 1'b0, 1'b0, c_LAT_ZERO};
        vecs[2] = '{32'h7F7FFFF0, 32'h41A00000, 32'h7F800000, 1'b1, 1'b0, c_LAT_RUN};
        vecs[3] = '{32'hFF7FFFF0, 32'h41A00000, 32'hFF800000, 1'b1, 1'b0, c_LAT_RUN};
        vecs[4] = '{32'h80000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, c_LAT_ZERO};
        vecs[5] = '{32'h3F800000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, c_LAT_ZERO};
        vecs[6] = '{32'h4EA0C8E4, 32'h4EA0C246, 32'h5DC9EF25, 1'b0, 1'b0, c_LAT_RUN};
        vecs[7] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, c_LAT_RUN};
        e = standin(32'h7FC00000, 32'h00000001);
        vecs[8] = '{32'h7FC00000, 32'h00000001, e[31:0], e[33], e[32], c_LAT_RUN};

        // Reset state
        #23;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mul_a", mul_a, 32'd0);
        chk("rst_mul_b", mul_b, 32'd0);
        chk("rst_mul_rst", {31'd0, mul_rst}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {30'd0, out_of, out_uf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        cycle();

        // Table of single operations
        for (int i = 0; i < 9; i++) run_single(vecs[i], $sformatf("vec%0d", i));

        // Three back-to-back pushes while the consumer stalls
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = (i == 0) ? 32'h4EA0C8E4 : (i == 1) ? 32'h49072340 : 32'h00000000;
            in_b = (i == 0) ? 32'h4EA0C246 : (i == 1) ? 32'h44520000 : 32'hCE8EF06B;
            cycle();
        end
        in_valid = 1'b0;
        chk("b2b_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 200) begin
            cycle();
            n++;
        end
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        repeat (10) cycle();
        chk("b2b_held_result", out_result, 32'h5DC9EF25);
        chk("b2b_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        cycle();
        chk("b2b_next_popped", mul_a, 32'h49072340);
        chk("b2b_no_bubble", {31'd0, mul_rst & busy & !out_valid}, 32'd1);
        chk("b2b_in_ready_back", {31'd0, in_ready}, 32'd1);
        wait_idle("b2b_idle");

        // Reset pulled mid-run with two more pairs waiting
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 32'h40490FDB + 32'(i);
            in_b = 32'hC0000000 + 32'(i);
            cycle();
        end
        in_valid = 1'b0;
        n = 0;
        while (mul_rst && n < 20) begin
            cycle();
            n++;
        end
        chk("mid_run_started", {31'd0, mul_rst}, 32'd0);
        repeat (20) cycle();
        reset = 1'b0;
        exp_q.delete();
        n_ops = 0;
        n_byp = 0;
        #1;
        chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_mul_rst", {31'd0, mul_rst}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_mul_a", mul_a, 32'd0);
        chk("mid_out_result", out_result, 32'd0);
        repeat (3) cycle();
        reset = 1'b1;
        repeat (5) cycle();
        chk("post_no_stale_valid", {31'd0, out_valid}, 32'd0);
        chk("post_fifo_empty", {31'd0, busy}, 32'd0);
        v = '{32'h3F800000, 32'h4EA0C8E4, 32'h4EA0C8E4, 1'b0, 1'b0, c_LAT_RUN};
        run_single(v, "post_reset");

        // Random traffic against the scoreboard
        left = 30;
        n = 0;
        while (left > 0 && n < 20000) begin
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(3) == 0) begin
                if ($urandom_range(1) == 0) ra[30:0] = 31'd0;
                else                        rb[30:0] = 31'd0;
            end
            in_valid  = ($urandom_range(1) == 1);
            in_a      = ra;
            in_b      = rb;
            out_ready = ($urandom_range(3) != 0);
            if (in_valid && in_ready) left--;
            cycle();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_all_sent", 32'(left), 32'd0);
        wait_idle("rand_idle");
        chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FP_MULT_SEQ_PERF_EN
        chk("perf_ops", {16'd0, perf_ops}, 32'(n_ops));
        chk("perf_bypass", {16'd0, perf_bypass}, 32'(n_byp));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
